// File: rtl/pkg_top_pulsos.sv
// Shared pulse-chain definitions.
// Idle level, debounce states and bench window size.
package pkg_top_pulsos;

  localparam logic DETECTED_SLOPE = 1'b1;

  localparam int DEBOUNCE_CYCLES_SIM = 4;

  typedef enum logic {
    IDLE,
    CHECK
  } debounce_state_e;

endpackage

// File: rtl/sync_ff_chain.sv
// Flop chain synchronizer for one asynchronous input.
// Reusable for any pin that enters the clock domain.
module sync_ff_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // plain shift chain, nothing between stages
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ff_q <= {STAGES{RST_VAL}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/debounce_boton.sv
// Push-button debouncer: synchronizer plus stability FSM.
// Output flips only after a new level holds for the full window.
module debounce_boton
  import pkg_top_pulsos::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic button_i,
  output logic button_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic IDLE_LVL = ~DETECTED_SLOPE;
  // the IDLE cycle that spots the change is the first
  // qualifying clock, so CHECK commits one count early
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_s;
  debounce_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;

  sync_ff_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (IDLE_LVL)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (button_i),
    .q_o     (sync_s)
  );

  // state, count and debounced level registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_q   <= IDLE_LVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
    end
  end

  // qualify a level change; any bounce back restarts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync_s != btn_q) begin
          state_d = CHECK;
          cnt_d   = CNT_W'(1);
        end
      end
      CHECK: begin
        if (sync_s == btn_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          btn_d   = ~btn_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign button_o = btn_q;
  assign busy_o   = (state_q == CHECK);

endmodule

// File: tb/tb_debounce_boton.sv
// Randomized bench for debounce_boton.
// Run-length reference model plus directed edge checks.
module tb_debounce_boton;
  import pkg_top_pulsos::*;

  localparam int DB = DEBOUNCE_CYCLES_SIM;
  localparam int SS = 2;
  localparam logic IDLE_LVL = ~DETECTED_SLOPE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button_i = IDLE_LVL;
  logic button_o;
  logic busy_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounce_boton #(
    .DEBOUNCE_CYCLES (DB),
    .SYNC_STAGES     (SS)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .button_i (button_i),
    .button_o (button_o),
    .busy_o   (busy_o)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // reference: pin delayed SS clocks, then count
  // consecutive clocks that differ from the output
  logic [SS-1:0] m_dly = {SS{IDLE_LVL}};
  int   m_run = 0;
  logic m_out = IDLE_LVL;
  logic m_busy;

  assign m_busy = (m_run != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dly <= {SS{IDLE_LVL}};
      m_run <= 0;
      m_out <= IDLE_LVL;
    end else begin
      m_dly <= {m_dly[SS-2:0], button_i};
      if (m_dly[SS-1] == m_out) begin
        m_run <= 0;
      end else if (m_run + 1 == DB) begin
        m_out <= ~m_out;
        m_run <= 0;
      end else begin
        m_run <= m_run + 1;
      end
    end
  end

  int   cyc = 0;
  int   last_tgl = 0;
  bit   have_tgl = 0;
  logic prev_out = IDLE_LVL;
  int   rises = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("out_model", button_o, m_out);
    chk("busy_model", busy_o, m_busy);
    if (!rst_n) begin
      have_tgl = 0;
    end else if (button_o !== prev_out) begin
      if (have_tgl)
        chk("spacing", (cyc - last_tgl) >= DB, 1);
      if (button_o == DETECTED_SLOPE) rises++;
      last_tgl = cyc;
      have_tgl = 1;
    end
    prev_out = button_o;
  end

  initial begin
    int   r0;
    bit   seen;
    int   hold;

    // 1: reset and quiet idle
    step();
    chk("rst_out", button_o, IDLE_LVL);
    chk("rst_busy", busy_o, 0);
    step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("idle_out", button_o, IDLE_LVL);
    chk("idle_busy", busy_o, 0);

    // 2: clean press then release
    button_i = DETECTED_SLOPE;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("press_out", button_o,
          (k >= SS + DB) ? DETECTED_SLOPE : IDLE_LVL);
      chk("press_busy", busy_o,
          (k > SS && k < SS + DB) ? 1 : 0);
    end
    button_i = IDLE_LVL;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("rel_out", button_o,
          (k >= SS + DB) ? IDLE_LVL : DETECTED_SLOPE);
      chk("rel_busy", busy_o,
          (k > SS && k < SS + DB) ? 1 : 0);
    end

    // 3: bounce then settle high
    r0 = rises;
    for (int i = 0; i < 8; i++) begin
      button_i = (i % 2 == 0) ? DETECTED_SLOPE : IDLE_LVL;
      step();
      chk("bounce_out", button_o, IDLE_LVL);
    end
    button_i = DETECTED_SLOPE;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("settle_out", button_o,
          (k >= SS + DB) ? DETECTED_SLOPE : IDLE_LVL);
    end
    chk("one_pulse", rises - r0, 1);
    button_i = IDLE_LVL;
    repeat (10) step();

    // 4: short glitches never commit
    seen = 0;
    button_i = DETECTED_SLOPE;
    step();
    button_i = IDLE_LVL;
    repeat (8) begin
      step();
      if (busy_o) seen = 1;
    end
    chk("glitch1_busy_seen", seen, 1);
    chk("glitch1_out", button_o, IDLE_LVL);
    seen = 0;
    button_i = DETECTED_SLOPE;
    repeat (3) step();
    button_i = IDLE_LVL;
    repeat (10) begin
      step();
      if (busy_o) seen = 1;
    end
    chk("glitch3_busy_seen", seen, 1);
    chk("glitch3_out", button_o, IDLE_LVL);
    chk("glitch3_busy", busy_o, 0);

    // 5: reset in the middle of qualification
    button_i = DETECTED_SLOPE;
    repeat (4) step();
    chk("pre_rst_busy", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out", button_o, IDLE_LVL);
    chk("async_busy", busy_o, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("requal_out", button_o,
          (k >= SS + DB) ? DETECTED_SLOPE : IDLE_LVL);
    end
    button_i = IDLE_LVL;
    repeat (10) step();

    // 6: random press/release activity
    for (int e = 0; e < 20; e++) begin
      button_i = ~button_i;
      hold = $urandom_range(1, 10);
      repeat (hold) step();
    end
    repeat (12) step();
    chk("final_out", button_o, button_i);
    chk("final_busy", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
